// File: rtl/tx_pkg.sv
// Shared definitions for the framed parallel-in/serial-out transmitter.
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - parity mode codes (PAR_NONE, PAR_EVEN, PAR_ODD)
//   - cnt_width(): counter width for a modulus, never below one bit
package tx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // A modulus of 1 still needs a 1-bit register to keep the code regular.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// bit_timer: DIV-cycle down counter that paces every serial bit.
//   clk  in  clock
//   rst  in  asynchronous active-high reset (counter -> 0)
//   load in  reload DIV-1 (asserted on entry into each bit period)
//   tick out high during the last cycle of the current bit period
// The counter parks at zero instead of wrapping, so DIV=1 gives a permanent
// tick and the count never underflows.
module bit_timer
    import tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed serial transmitter.
// Frame on Sout: start(0), WIDTH data bits, optional parity, stop(1); each
// bit held DIV cycles; line idles high.
//   Cp        in   clock
//   Rst       in   asynchronous active-high reset, discards any frame
//   Din       in   word to send, latched when Valid && Ready on a rising Cp
//   Valid     in   Din is valid
//   Ready     out  idle, a word can be accepted this cycle
//   Sout      out  registered serial line
//   Busy      out  frame in progress
//   Done      out  one-cycle pulse in the first idle cycle after STOP
//   dbg_state out  current FSM state (tx_pkg encoding)
// Handshake: a word transfers on the rising Cp where Valid && Ready; Valid
// while not Ready is ignored and nothing is queued.
module piso_serial_tx
    import tx_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIV     = 4,
    parameter int LSB_1ST = 1,
    parameter int PARITY  = 0
) (
    input  logic             Cp,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Din,
    input  logic             Valid,
    output logic             Ready,
    output logic             Sout,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       dbg_state
);

    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q,   bit_d;
    logic             par_q,   par_d;
    logic             sout_q,  sout_d;
    logic             done_q,  done_d;

    logic             accept;
    logic             tick;
    logic             timer_load;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    assign accept = Valid && (state_q == S_IDLE);

    // Reload on every bit-period boundary except the end of STOP, where the
    // counter is simply left at zero until the next word arrives.
    assign timer_load = accept ||
                        (tick && (state_q != S_IDLE) && (state_q != S_STOP));

    bit_timer #(.DIV(DIV)) u_timer (
        .clk  (Cp),
        .rst  (Rst),
        .load (timer_load),
        .tick (tick)
    );

    // The bit about to go on the line is always at the outgoing end of the
    // shift register; it is consumed as it is loaded into sout.
    assign next_bit = (LSB_1ST != 0) ? shift_q[0] : shift_q[WIDTH-1];
    assign shifted  = (LSB_1ST != 0) ? (shift_q >> 1) : (shift_q << 1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                sout_d = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    sout_d  = 1'b0;
                    shift_d = Din;
                    bit_d   = '0;
                    par_d   = (PARITY == PAR_ODD) ? ~(^Din) : (^Din);
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    sout_d  = next_bit;
                    shift_d = shifted;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = S_PARITY;
                            sout_d  = par_q;
                        end else begin
                            state_d = S_STOP;
                            sout_d  = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sout_d  = next_bit;
                        shift_d = shifted;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    sout_d  = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    sout_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sout_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Cp or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            sout_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign Ready     = (state_q == S_IDLE);
    assign Busy      = ~Ready;
    assign Sout      = sout_q;
    assign Done      = done_q;
    assign dbg_state = state_q;

endmodule
